rstack_ctrl: RTL and testbench

Return-stack control stage for the J1-style CPU core. Sits directly upstream of the return stack memory: decodes each accepted instruction's call/return/T→R fields, holds the architectural return-stack pointer, and drives `rsk_data`, `rsp_n` and `rsk_wen` into the stack. It also detects overflow/underflow, halts issue through a fault state machine, and tracks a stack-depth high-water mark.

---
 rtl/rstack_ctrl.sv | 62 ++++++
 tb/tb_rstack_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rstack_ctrl.sv
// rstack_ctrl: J1 return-stack pointer control with overflow/underflow fault FSM and depth high-water mark.
module rstack_ctrl #(
  parameter int DEPTH_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        insn_valid,
  output logic        insn_ready,
  input  logic [15:0] insn,
  input  logic [15:0] ret_addr,
  input  logic [15:0] T,
  input  logic        fault_clr,
  output logic [15:0] rsk_data,
  output logic [7:0]  rsp_n,
  output logic        rsk_wen,
  output logic [7:0]  rsp,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [7:0]  hwm
);
  typedef enum logic {RUN, FAULT} state_t;
  state_t state, state_n;
  logic call, alu, wr, accept, ovf, unf, flt;
  logic [1:0] d;
  logic [9:0] nxt;
  always_comb begin
    call = !insn[15] && insn[14:13] == 2'b10;
    alu = !insn[15] && insn[14:13] == 2'b11;
    d = call ? 2'b01 : alu ? insn[3:2] : 2'b00;
    wr = call || (alu && insn[6]);
    // 10-bit sum: bit 9 set means the pointer went below zero
    nxt = {2'b00, rsp} + {{8{d[1]}}, d};
    ovf = d == 2'b01 && nxt > 10'(DEPTH_MAX);
    unf = d[1] && nxt[9];
    insn_ready = rst_n && state == RUN;
    accept = insn_valid && insn_ready;
    flt = accept && (ovf || unf);
    rsk_wen = accept && wr && !flt;
    rsp_n = accept && !flt ? nxt[7:0] : rsp;
    rsk_data = call ? ret_addr : T;
    state_n = state == RUN ? (flt ? FAULT : RUN) : (fault_clr ? RUN : FAULT);
  end
  assign fault = state == FAULT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0;
      fault_code <= '0;
      hwm <= '0;
    end else if (state == FAULT && fault_clr) begin
      rsp <= '0;
      fault_code <= '0;
    end else if (flt) begin
      fault_code <= ovf ? 2'b01 : 2'b10;
    end else if (accept) begin
      rsp <= rsp_n;
      if (rsp_n > hwm) hwm <= rsp_n;
    end
  end
endmodule

// File: tb/tb_rstack_ctrl.sv
// tb_rstack_ctrl: table-driven, directed and randomized checks of rstack_ctrl against an arithmetic stack model.
module tb_rstack_ctrl;
  logic clk = 0, rst_n = 0, insn_valid = 0, fault_clr = 0;
  logic [15:0] insn = 0, ret_addr = 0, T = 0;
  logic insn_ready, rsk_wen, fault;
  logic [15:0] rsk_data;
  logic [7:0] rsp_n, rsp, hwm;
  logic [1:0] fault_code;
  int checks = 0, errors = 0;
  int m_rsp = 0, m_hwm = 0, m_code = 0;
  bit m_flt = 0;
  rstack_ctrl dut (.clk(clk), .rst_n(rst_n), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn(insn), .ret_addr(ret_addr), .T(T), .fault_clr(fault_clr), .rsk_data(rsk_data),
    .rsp_n(rsp_n), .rsk_wen(rsk_wen), .rsp(rsp), .fault(fault), .fault_code(fault_code), .hwm(hwm));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(input bit v, input logic [15:0] i, input logic [15:0] ra, input logic [15:0] td,
                      input bit clr, output int wen_o, output int rspn_o, output int data_o);
    int dl, nw;
    bit w, bad, acc, is_call;
    insn_valid = v; insn = i; ret_addr = ra; T = td; fault_clr = clr;
    dl = 0; w = 0;
    is_call = !i[15] && i[14:13] == 2'b10;
    if (is_call) begin dl = 1; w = 1; end
    else if (!i[15] && i[14:13] == 2'b11) begin
      dl = i[3:2] == 0 ? 0 : i[3:2] == 1 ? 1 : i[3:2] == 2 ? -2 : -1;
      w = i[6];
    end
    nw = m_rsp + dl;
    bad = nw > 255 || nw < 0;
    acc = v && !m_flt;
    #1;
    wen_o = rsk_wen; rspn_o = rsp_n; data_o = rsk_data;
    chk("insn_ready", insn_ready, !m_flt);
    chk("rsk_wen", rsk_wen, acc && w && !bad);
    chk("rsp_n", rsp_n, (acc && !bad) ? nw : m_rsp);
    chk("rsk_data", rsk_data, is_call ? ra : td);
    @(posedge clk);
    #1;
    fault_clr = 0;
    if (m_flt && clr) begin m_rsp = 0; m_code = 0; m_flt = 0; end
    else if (acc && bad) begin m_flt = 1; m_code = nw > 255 ? 1 : 2; end
    else if (acc) begin m_rsp = nw; if (nw > m_hwm) m_hwm = nw; end
    chk("rsp", rsp, m_rsp);
    chk("fault", fault, m_flt);
    chk("fault_code", fault_code, m_code);
    chk("hwm", hwm, m_hwm);
  endtask
  typedef struct {
    logic [15:0] i, ra, td;
    int wen, rspn, data, rsp_after, hwm_after;
  } vec_t;
  vec_t tbl[$];
  int w, rn, dt;
  logic [15:0] ri;
  initial begin
    tbl = '{
      '{16'h4000, 16'h0100, 16'h0000, 1, 1, 16'h0100, 1, 1},
      '{16'h4000, 16'h0101, 16'h0000, 1, 2, 16'h0101, 2, 2},
      '{16'h4000, 16'h0102, 16'h0000, 1, 3, 16'h0102, 3, 3},
      '{16'h600C, 16'h0103, 16'h1111, 0, 2, 16'h1111, 2, 3},
      '{16'h600C, 16'h0104, 16'h2222, 0, 1, 16'h2222, 1, 3},
      '{16'h600C, 16'h0105, 16'h3333, 0, 0, 16'h3333, 0, 3},
      '{16'h4000, 16'h0201, 16'h0000, 1, 1, 16'h0201, 1, 3},
      '{16'h4000, 16'h0202, 16'h0000, 1, 2, 16'h0202, 2, 3},
      '{16'h4000, 16'h0203, 16'h0000, 1, 3, 16'h0203, 3, 3},
      '{16'h4000, 16'h0204, 16'h0000, 1, 4, 16'h0204, 4, 4},
      '{16'h6044, 16'h0000, 16'hBEEF, 1, 5, 16'hBEEF, 5, 5},
      '{16'h8005, 16'h0000, 16'h1234, 0, 5, 16'h1234, 5, 5},
      '{16'h0123, 16'h0000, 16'h4321, 0, 5, 16'h4321, 5, 5},
      '{16'h6040, 16'h0000, 16'hCAFE, 1, 5, 16'hCAFE, 5, 5},
      '{16'h6008, 16'h0000, 16'h0000, 0, 3, 16'h0000, 3, 5},
      '{16'h6008, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 5}
    };
    #1;
    chk("reset rsp", rsp, 0);
    chk("reset wen", rsk_wen, 0);
    chk("reset rsp_n", rsp_n, 0);
    chk("reset fault", fault, 0);
    chk("reset code", fault_code, 0);
    chk("reset hwm", hwm, 0);
    #11 rst_n = 1;
    foreach (tbl[k]) begin
      step(1, tbl[k].i, tbl[k].ra, tbl[k].td, 0, w, rn, dt);
      chk("tbl wen", w, tbl[k].wen);
      chk("tbl rsp_n", rn, tbl[k].rspn);
      chk("tbl data", dt, tbl[k].data);
      chk("tbl rsp", rsp, tbl[k].rsp_after);
      chk("tbl hwm", hwm, tbl[k].hwm_after);
    end
    // underflow by -2 at depth 1, then stall while faulted
    step(1, 16'h6008, 0, 0, 0, w, rn, dt);
    chk("unf2 code", fault_code, 2);
    chk("unf2 rsp", rsp, 1);
    step(1, 16'h4000, 16'h7777, 0, 0, w, rn, dt);
    chk("stall rsp", rsp, 1);
    chk("stall ready", insn_ready, 0);
    step(0, 0, 0, 0, 1, w, rn, dt);
    chk("clr rsp", rsp, 0);
    chk("clr fault", fault, 0);
    step(1, 16'h600C, 0, 0, 0, w, rn, dt);
    chk("unf1 code", fault_code, 2);
    step(0, 0, 0, 0, 1, w, rn, dt);
    step(1, 16'h4000, 16'h0001, 0, 0, w, rn, dt);
    step(0, 0, 0, 0, 1, w, rn, dt);
    chk("clr in run rsp", rsp, 1);
    chk("clr in run fault", fault, 0);
    step(1, 16'h600C, 0, 0, 0, w, rn, dt);
    for (int k = 0; k < 255; k++) step(1, 16'h4000, 16'(k), 0, 0, w, rn, dt);
    chk("full rsp", rsp, 255);
    step(1, 16'h4000, 16'hDEAD, 0, 0, w, rn, dt);
    chk("ovf wen", w, 0);
    chk("ovf rsp", rsp, 255);
    chk("ovf code", fault_code, 1);
    chk("ovf ready", insn_ready, 0);
    step(0, 0, 0, 0, 1, w, rn, dt);
    chk("ovf clr rsp", rsp, 0);
    chk("ovf clr hwm", hwm, 255);
    for (int k = 0; k < 7; k++) step(1, 16'h4000, 16'(k), 0, 0, w, rn, dt);
    insn_valid = 1; insn = 16'h4000; ret_addr = 16'h5555;
    #1 chk("pre-reset wen", rsk_wen, 1);
    rst_n = 0;
    #1;
    chk("areset rsp", rsp, 0);
    chk("areset wen", rsk_wen, 0);
    chk("areset rsp_n", rsp_n, 0);
    chk("areset code", fault_code, 0);
    chk("areset hwm", hwm, 0);
    m_rsp = 0; m_hwm = 0; m_code = 0; m_flt = 0;
    insn_valid = 0;
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0: ri = 16'h8000 | 16'($urandom_range(0, 32767));
        1: ri = 16'($urandom_range(0, 16383));
        2, 3: ri = 16'h4000 | 16'($urandom_range(0, 8191));
        default: ri = 16'h6000 | 16'($urandom_range(0, 8191));
      endcase
      step($urandom_range(0, 3) != 0, ri, 16'($urandom), 16'($urandom), $urandom_range(0, 4) == 0, w, rn, dt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
